// File: rtl/multiplier_param.sv
// rtl/multiplier_param.sv - iterative chunked RISC-V M multiplier (MUL/MULH/MULHSU/MULHU); optional result cache under MULT_OPERAND_CACHE_EN
module multiplier_param #(
    parameter int XLEN = 32,
    parameter int PW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int N     = XLEN / PW;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = 2 * XLEN + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;

    state_t state_q, state_d;
    op_t    op_in, op_q;

    logic              a_neg_in, b_neg_in, neg_q;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, a_mag_q, b_mag_q;
    logic [ACC_W-1:0]  acc_q, acc_sum, term;
    logic [CW-1:0]     ci_q, cj_q;
    logic [PW-1:0]     a_chunk, b_chunk;
    logic [2*PW-1:0]   prod;
    logic [31:0]       shift, pair_next;
    logic              mul_wrap, last_round, accept, hit;
    logic [2*XLEN-1:0] signed_full;
    logic [XLEN-1:0]   res_sel, hit_res;

    // Decode funct3; unlisted codes behave as MULHU
    always_comb begin
        case (funct3_i)
            3'b000:  op_in = OP_MUL;
            3'b001:  op_in = OP_MULH;
            3'b010:  op_in = OP_MULHSU;
            default: op_in = OP_MULHU;
        endcase
    end

    assign a_neg_in = (op_in == OP_MULH || op_in == OP_MULHSU) && a_i[XLEN-1];
    assign b_neg_in = (op_in == OP_MULH) && b_i[XLEN-1];
    assign a_mag_in = a_neg_in ? -a_i : a_i;
    assign b_mag_in = b_neg_in ? -b_i : b_i;

    assign accept  = (state_q == IDLE) && valid_i && !kill_i;
    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);

    // One PW x PW product per round, placed at its chunk offset
    assign a_chunk   = a_mag_q[32'(ci_q) * 32'(PW) +: PW];
    assign b_chunk   = b_mag_q[32'(cj_q) * 32'(PW) +: PW];
    assign prod      = {{PW{1'b0}}, a_chunk} * {{PW{1'b0}}, b_chunk};
    assign shift     = 32'(PW) * (32'(ci_q) + 32'(cj_q));
    assign term      = ACC_W'(prod) << shift;
    assign acc_sum   = acc_q + term;
    assign pair_next = 32'(ci_q) + 32'(cj_q) + 32'd1;
    assign mul_wrap  = pair_next >= 32'(N);

    // MUL only needs pairs landing in the low half; its final pair is (0, N-1)
    assign last_round = (op_q == OP_MUL) ? (cj_q == LAST_IDX)
                                         : (ci_q == LAST_IDX && cj_q == LAST_IDX);

    assign signed_full = neg_q ? -acc_sum[2*XLEN-1:0] : acc_sum[2*XLEN-1:0];
    assign res_sel     = (op_q == OP_MUL) ? signed_full[XLEN-1:0] : signed_full[2*XLEN-1:XLEN];

`ifdef MULT_OPERAND_CACHE_EN
    logic              c_valid_q;
    logic [XLEN-1:0]   a_raw_q, b_raw_q, c_a_q, c_b_q;
    op_t               c_op_q;
    logic [2*XLEN-1:0] c_prod_q;

    // Low bits of the product are signedness-independent, so MUL may reuse any entry
    assign hit     = c_valid_q && (a_i == c_a_q) && (b_i == c_b_q)
                     && (op_in == OP_MUL || op_in == c_op_q);
    assign hit_res = (op_in == OP_MUL) ? c_prod_q[XLEN-1:0] : c_prod_q[2*XLEN-1:XLEN];

    // Cache fill on completed high-half ops; any kill drops the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_valid_q <= 1'b0;
            a_raw_q   <= '0;
            b_raw_q   <= '0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_op_q    <= OP_MUL;
            c_prod_q  <= '0;
        end else begin
            if (accept) begin
                a_raw_q <= a_i;
                b_raw_q <= b_i;
            end
            if (state_q != IDLE && kill_i) begin
                c_valid_q <= 1'b0;
            end else if (state_q == BUSY && last_round && op_q != OP_MUL) begin
                c_valid_q <= 1'b1;
                c_a_q     <= a_raw_q;
                c_b_q     <= b_raw_q;
                c_op_q    <= op_q;
                c_prod_q  <= signed_full;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: kill beats completion, consumption and acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (valid_i && !kill_i) state_d = hit ? DONE : BUSY;
            BUSY: begin
                if (kill_i)          state_d = IDLE;
                else if (last_round) state_d = DONE;
            end
            DONE: if (kill_i || ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, accumulation, chunk walk and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            ci_q     <= '0;
            cj_q     <= '0;
            result_o <= '0;
        end else if (accept) begin
            a_mag_q <= a_mag_in;
            b_mag_q <= b_mag_in;
            op_q    <= op_in;
            neg_q   <= a_neg_in ^ b_neg_in;
            acc_q   <= '0;
            ci_q    <= '0;
            cj_q    <= '0;
            if (hit) result_o <= hit_res;
        end else if (state_q == BUSY && !kill_i) begin
            acc_q <= acc_sum;
            if (last_round) begin
                result_o <= res_sel;
            end else if ((op_q == OP_MUL) ? mul_wrap : (ci_q == LAST_IDX)) begin
                ci_q <= '0;
                cj_q <= cj_q + 1'b1;
            end else begin
                ci_q <= ci_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_multiplier_param.sv
// tb/tb_multiplier_param.sv - self-checking bench for multiplier_param (XLEN=32, PW=16)
module tb_multiplier_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, kill_i, valid_o, ready_i;
    logic [2:0]  funct3_i;
    logic [31:0] a_i, b_i, result_o;

    int total = 0;
    int bad   = 0;

    multiplier_param #(.XLEN(32), .PW(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .funct3_i(funct3_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i),
        .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference arithmetic: exact product via 64-bit integers
    function automatic logic [63:0] full_prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint ea, eb;
        ea = (f3 == 3'b001 || f3 == 3'b010) ? longint'($signed(a)) : longint'({32'd0, a});
        eb = (f3 == 3'b001) ? longint'($signed(b)) : longint'({32'd0, b});
        return 64'(ea * eb);
    endfunction

    function automatic logic [31:0] pick(input logic [2:0] f3, input logic [63:0] p);
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [2:0] norm(input logic [2:0] f3);
        return (f3 > 3'd3) ? 3'd3 : f3;
    endfunction

    // Transaction-level model: phase 0 idle, 1 computing, 2 holding a result
    int          m_phase, m_left;
    logic [31:0] m_res, m_a, m_b;
    logic [2:0]  m_f;
    logic        mc_valid;
    logic [31:0] mc_a, mc_b;
    logic [2:0]  mc_f;
    logic [63:0] mc_p;

    function automatic logic m_hit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_OPERAND_CACHE_EN
        return mc_valid && a == mc_a && b == mc_b && (f3 == 3'b000 || norm(f3) == mc_f);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_left <= 0; m_res <= '0; mc_valid <= 1'b0;
            m_a <= '0; m_b <= '0; m_f <= '0; mc_a <= '0; mc_b <= '0; mc_f <= '0; mc_p <= '0;
        end else begin
            case (m_phase)
                0: if (valid_i && !kill_i) begin
                    if (m_hit(funct3_i, a_i, b_i)) begin
                        m_phase <= 2;
                        m_res   <= pick(funct3_i, mc_p);
                    end else begin
                        m_phase <= 1;
                        m_left  <= (funct3_i == 3'b000) ? 3 : 4;
                        m_f <= funct3_i; m_a <= a_i; m_b <= b_i;
                    end
                end
                1: if (kill_i) begin
                    m_phase <= 0; mc_valid <= 1'b0;
                end else if (m_left == 1) begin
                    m_phase <= 2;
                    m_res   <= pick(m_f, full_prod(m_f, m_a, m_b));
                    if (m_f != 3'b000) begin
                        mc_valid <= 1'b1; mc_a <= m_a; mc_b <= m_b;
                        mc_f <= norm(m_f); mc_p <= full_prod(m_f, m_a, m_b);
                    end
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (kill_i) begin
                    m_phase <= 0; mc_valid <= 1'b0;
                end else if (ready_i) begin
                    m_phase <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(posedge clk) begin
        #1;
        chk("mon_ready", 64'(ready_o), 64'(m_phase == 0));
        chk("mon_valid", 64'(valid_o), 64'(m_phase == 2));
        chk("mon_result", 64'(result_o), 64'(m_res));
    end

    task automatic do_op(input string nm, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_busy, input int hold);
        int busy;
        @(negedge clk);
        valid_i = 1'b1; funct3_i = f3; a_i = a; b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        busy = 0;
        while (!valid_o && busy < 40) begin
            busy++;
            @(posedge clk); #1;
        end
        chk({nm, "_busy"}, 64'(busy), 64'(exp_busy));
        chk({nm, "_res"}, 64'(result_o), 64'(exp_r));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({nm, "_hold_valid"}, 64'(valid_o), 64'd1);
            chk({nm, "_hold_res"}, 64'(result_o), 64'(exp_r));
        end
        @(negedge clk); ready_i = 1'b1;
        @(posedge clk); #1; ready_i = 1'b0;
        chk({nm, "_idle"}, 64'(ready_o), 64'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_result", 64'(result_o), 64'd0);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b0;
        funct3_i = '0; a_i = '0; b_i = '0;
        #2;
        chk("reset_ready", 64'(ready_o), 64'd1);
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_result", 64'(result_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 0);
        do_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4, 0);
        do_op("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4, 0);
        do_op("mulhsu_ff", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0);
        do_op("mul_small", 3'b000, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 0);
        do_op("f3_111_hold", 3'b111, 32'h0002_0000, 32'h0003_0000, 32'h0000_0006, 4, 5);

        // kill during the second round
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'b011; a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF;
        @(posedge clk); #1; valid_i = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); kill_i = 1'b1;
        @(posedge clk); #1; kill_i = 1'b0;
        chk("kill_ready", 64'(ready_o), 64'd1);
        chk("kill_valid", 64'(valid_o), 64'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("kill_no_valid", 64'(valid_o), 64'd0);
        end

        // reset in the middle of an operation
        @(negedge clk);
        valid_i = 1'b1; funct3_i = 3'b001; a_i = 32'h8000_0000; b_i = 32'h8000_0000;
        @(posedge clk); #1; valid_i = 1'b0;
        @(posedge clk); #1;
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("midrst_no_valid", 64'(valid_o), 64'd0);
        end

        // cache reuse, then reuse denied after reset
        do_op("c_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 0);
`ifdef MULT_OPERAND_CACHE_EN
        do_op("c_mul_hit", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
`else
        do_op("c_mul_nohit", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 0);
`endif
        pulse_reset();
        do_op("c_mul_after_rst", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 3, 0);

        // randomized traffic checked by the per-cycle monitor
        for (int it = 0; it < 1500; it++) begin
            @(negedge clk);
            if (it == 700) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            valid_i  = ($urandom_range(0, 1) == 1);
            funct3_i = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 5))
                    0: a_i = 32'h0;
                    1: a_i = 32'hFFFF_FFFF;
                    2: a_i = 32'h8000_0000;
                    3: a_i = 32'h7FFF_FFFF;
                    4: a_i = 32'h0001_0003;
                    default: a_i = 32'h1234_5678;
                endcase
                case ($urandom_range(0, 3))
                    0: b_i = 32'hFFFF_FFFF;
                    1: b_i = 32'h8000_0000;
                    2: b_i = 32'h0002_0005;
                    default: b_i = 32'h1;
                endcase
            end else begin
                a_i = $urandom;
                b_i = $urandom;
            end
            ready_i = ($urandom_range(0, 2) != 0);
            kill_i  = ($urandom_range(0, 19) == 0);
        end

        @(negedge clk);
        valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
